exec_trace_buffer: RTL and testbench

EXEC_TRACE_BUFFER -- requirements
Module: exec_trace_buffer

---
 rtl/riscv_trace_pkg.sv | 35 +++
 rtl/trace_fifo2w.sv | 61 ++++++
 rtl/exec_trace_buffer.sv | 102 ++++++++++
 tb/tb_exec_trace_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared trace definitions: event kinds, the stamp-less entry payload and a
// constructor used by the trace buffer.
package riscv_trace_pkg;

  localparam int unsigned KIND_W = 2;
  localparam int unsigned TAG_W  = 9;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [KIND_W-1:0] {
    KIND_NONE = 2'b00,
    KIND_REG  = 2'b01,
    KIND_MEMW = 2'b10,
    KIND_MEMR = 2'b11
  } trace_kind_t;

  // The stamp width is a parameter of the buffer, so it is appended outside the struct.
  typedef struct packed {
    trace_kind_t         kind;
    logic [TAG_W-1:0]    tag;
    logic [DATA_W-1:0]   data;
  } trace_entry_t;

  localparam int unsigned PAYLOAD_W = $bits(trace_entry_t);

  function automatic trace_entry_t make_entry(input trace_kind_t       kind,
                                              input logic [TAG_W-1:0]  tag,
                                              input logic [DATA_W-1:0] data);
    trace_entry_t e;
    e.kind = kind;
    e.tag  = tag;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo2w.sv
// Synchronous FIFO with two write ports and one read port; port 1 lands
// directly behind port 0 when both write in the same cycle.
module trace_fifo2w #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 59
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr0_en_i,
  input  logic [W-1:0]               wr0_data_i,
  input  logic                       wr1_en_i,
  input  logic [W-1:0]               wr1_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr1_addr;
  logic          pop;
  logic [CW-1:0] n_wr;

  always_comb begin
    pop      = rd_en_i && (count_q != '0);
    n_wr     = CW'(wr0_en_i) + CW'(wr1_en_i);
    wr1_addr = wr0_en_i ? AW'(wptr_q + AW'(1)) : wptr_q;
    // Pointers are exactly AW bits wide, so natural overflow is the modulo-DEPTH wrap.
    wptr_d   = AW'(wptr_q + AW'(n_wr));
    rptr_d   = pop ? AW'(rptr_q + AW'(1)) : rptr_q;
    count_d  = CW'(count_q + n_wr - CW'(pop));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (wr0_en_i) mem_q[wptr_q]   <= wr0_data_i;
      if (wr1_en_i) mem_q[wr1_addr] <= wr1_data_i;
    end
  end

  assign rd_data_o = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/exec_trace_buffer.sv
// Execution trace capture: turns register-file and data-memory activity into
// stamped trace entries, buffered in a FIFO with all-or-nothing drop accounting.
module exec_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned STAMP_W = 16,
  parameter bit          DROP_X0 = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reg_we,
  input  logic [4:0]                    reg_num,
  input  logic [31:0]                   reg_data,
  input  logic                          mem_we,
  input  logic                          mem_re,
  input  logic [8:0]                    mem_addr,
  input  logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2+9+32+STAMP_W-1:0]     out_entry,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int unsigned ENTRY_W = PAYLOAD_W + STAMP_W;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic [STAMP_W-1:0] stamp_q;
  logic               overflow_q;
  logic [7:0]         drop_q, drop_d;

  logic               reg_ev, mem_ev;
  trace_entry_t       reg_ent, mem_ent;
  logic [1:0]         n_ev;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      free_slots;
  logic               pop;
  logic               accept;
  logic [8:0]         drop_sum;

  logic               wr0_en, wr1_en;
  logic [ENTRY_W-1:0] wr0_data, wr1_data;

  always_comb begin
    reg_ev  = reg_we && !(DROP_X0 && (reg_num == 5'd0));
    mem_ev  = mem_we ^ mem_re;
    reg_ent = make_entry(KIND_REG, {4'b0, reg_num}, reg_data);
    mem_ent = mem_we ? make_entry(KIND_MEMW, mem_addr, mem_wdata)
                     : make_entry(KIND_MEMR, mem_addr, mem_rdata);
    n_ev    = 2'(reg_ev) + 2'(mem_ev);

    // A pop in the same cycle frees its slot for this cycle's events.
    pop        = out_valid && out_ready;
    free_slots = CW'(CW'(DEPTH) - fifo_count + CW'(pop));
    accept     = CW'(n_ev) <= free_slots;

    // The REG event always takes the first write port so it lands ahead of memory.
    wr0_en   = accept && (reg_ev || mem_ev);
    wr0_data = reg_ev ? {reg_ent, stamp_q} : {mem_ent, stamp_q};
    wr1_en   = accept && reg_ev && mem_ev;
    wr1_data = {mem_ent, stamp_q};

    drop_sum = 9'(drop_q) + 9'(n_ev);
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stamp_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      stamp_q <= STAMP_W'(stamp_q + STAMP_W'(1));
      if (!accept) begin
        overflow_q <= 1'b1;
        drop_q     <= drop_d;
      end
    end
  end

  trace_fifo2w #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr0_en_i   (wr0_en),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_data_i (wr1_data),
    .rd_en_i    (out_ready),
    .rd_data_o  (out_entry),
    .count_o    (fifo_count)
  );

  assign out_valid  = (fifo_count != '0);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer: expected entries go into a scoreboard
// queue and a negedge monitor checks every accepted head entry against it.
module tb_exec_trace_buffer;

  localparam int unsigned EW = 59;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_we;
  logic [4:0]    reg_num;
  logic [31:0]   reg_data;
  logic          mem_we, mem_re;
  logic [8:0]    mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          out_valid, out_ready;
  logic [EW-1:0] out_entry;
  logic          overflow;
  logic [7:0]    drop_count;

  logic [15:0]   st = '0;
  logic [EW-1:0] sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  exec_trace_buffer #(
    .DEPTH   (16),
    .STAMP_W (16),
    .DROP_X0 (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_we     (reg_we),
    .reg_num    (reg_num),
    .reg_data   (reg_data),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_entry  (out_entry),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Stamp of the current cycle: restarts at 0 after every reset edge.
  always @(posedge clk) st <= !rst ? 16'd0 : 16'(st + 16'd1);

  function automatic logic [EW-1:0] ent(input logic [1:0] k, input logic [8:0] t,
                                        input logic [31:0] d, input logic [15:0] s);
    return {k, t, d, s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    reg_we = 0; reg_num = '0; reg_data = '0;
    mem_we = 0; mem_re = 0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
  endtask

  // Monitor: every head entry the consumer takes must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_entry: got %h expected none", out_entry);
        end else begin
          chk("entry", 64'(out_entry), 64'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 0; out_ready = 0;
    clear_in();
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_entry", 64'(out_entry), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // Stamp is 0 in the cycle after release, so three idle cycles reach stamp 3.
    rst = 1;
    tick(); tick(); tick();
    out_ready = 1;
    reg_we = 1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
    sb.push_back(ent(2'b01, 9'd5, 32'hDEADBEEF, 16'd3));
    chk("pre_valid", 64'(out_valid), 64'd0);
    tick(); clear_in();
    chk("valid_next", 64'(out_valid), 64'd1);
    tick();
    chk("drained_1", 64'(out_valid), 64'd0);

    // Dual event: REG first, then MEMW, equal stamps.
    reg_we = 1; reg_num = 5'd1; reg_data = 32'd7;
    mem_we = 1; mem_addr = 9'h1F0; mem_wdata = 32'h11; mem_rdata = 32'h55;
    sb.push_back(ent(2'b01, 9'd1, 32'd7, st));
    sb.push_back(ent(2'b10, 9'h1F0, 32'h11, st));
    tick(); clear_in();
    tick(); tick();
    chk("drained_2", 64'(out_valid), 64'd0);

    mem_re = 1; mem_addr = 9'h023; mem_rdata = 32'hCAFEF00D; mem_wdata = 32'h1234;
    sb.push_back(ent(2'b11, 9'h023, 32'hCAFEF00D, st));
    tick(); clear_in();
    tick();

    // Conflicting memory strobes plus an x0 write form no event at all.
    mem_we = 1; mem_re = 1; mem_addr = 9'h1; reg_we = 1; reg_num = 5'd0; reg_data = 32'h9;
    tick(); clear_in();
    chk("no_event_valid", 64'(out_valid), 64'd0);
    chk("no_event_drop", 64'(drop_count), 64'd0);
    chk("no_event_ovf", 64'(overflow), 64'd0);

    // Fill: 17 single events with the consumer stalled.
    out_ready = 0;
    for (int i = 0; i < 17; i++) begin
      reg_we = 1; reg_num = 5'(i % 31 + 1); reg_data = 32'h100 + 32'(i);
      if (i < 16) sb.push_back(ent(2'b01, 9'(i % 31 + 1), 32'h100 + 32'(i), st));
      tick();
    end
    clear_in();
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_drop1", 64'(drop_count), 64'd1);
    chk("full_valid", 64'(out_valid), 64'd1);
    reg_we = 1; reg_num = 5'd2; reg_data = 32'hAA; mem_re = 1; mem_addr = 9'd5;
    tick(); clear_in();
    chk("full_drop3", 64'(drop_count), 64'd3);
    tick(); tick();
    chk("hold_head", 64'(out_entry), 64'(sb[0]));

    // Pop and push together on a full FIFO: the push fits, occupancy stays full.
    out_ready = 1;
    reg_we = 1; reg_num = 5'd9; reg_data = 32'h999;
    sb.push_back(ent(2'b01, 9'd9, 32'h999, st));
    tick();
    chk("popfill_drop", 64'(drop_count), 64'd3);
    chk("popfill_ovf", 64'(overflow), 64'd1);
    out_ready = 0;
    reg_num = 5'd10; reg_data = 32'hAAA;
    tick(); clear_in();
    chk("still_full_drop4", 64'(drop_count), 64'd4);
    out_ready = 1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    chk("drain_done", 64'(out_valid), 64'd0);
    chk("sb_empty_1", 64'(sb.size()), 64'd0);

    // Reset with entries buffered discards them and restarts the stamp.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      reg_we = 1; reg_num = 5'(i + 20); reg_data = 32'(i);
      tick();
    end
    clear_in();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 0;
    reg_we = 1; reg_num = 5'd7; reg_data = 32'h77;
    tick(); clear_in();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_entry", 64'(out_entry), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_drop", 64'(drop_count), 64'd0);
    rst = 1;
    out_ready = 1;
    reg_we = 1; reg_num = 5'd3; reg_data = 32'h33;
    sb.push_back(ent(2'b01, 9'd3, 32'h33, 16'd0));
    tick(); clear_in();
    tick(); tick();
    chk("final_valid", 64'(out_valid), 64'd0);
    chk("sb_empty_2", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
